pool_window_gen: RTL and testbench
==================================

# pool_window_gen

Streams a raster-order feature-map plane in one pixel per cycle and emits non-overlapping 2x2 pooling windows, one window per handshake, for the pooling unit in the special-functions path. A single-row line buffer holds each even row. When the matching odd row arrives, each completed window is assembled and presented on a registered valid/ready output. The lane order matches the pooling unit's four-element input.

## Interface
- DATA_WIDTH, 16, pixel/lane width in bits
- MAX_WIDTH, 64, maximum supported row width in pixels (line-buffer depth)
- CW, $clog2(MAX_WIDTH)+1, width of configuration fields
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse; latches cfg_width/cfg_height and begins a frame
- cfg_width  in  CW  row width in pixels
- cfg_height  in  CW  number of rows
- pix_data  in  DATA_WIDTH  input pixel
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- win_data  out  4*DATA_WIDTH  window: [0]=top-left, [1]=top-right, [2]=bottom-left, [3]=bottom-right (lane k at bits k*DATA_WIDTH+:DATA_WIDTH)
- win_valid  out  1  window valid
- win_ready  in  1  window consumed when win_valid && win_ready
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last pixel of frame accepted
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- States: IDLE, EVEN_ROW, ODD_ROW.
- IDLE:
  - start with 2 <= cfg_width <= MAX_WIDTH and cfg_height >= 2 latches the config, clears row/col counters and goes to EVEN_ROW.
  - Any other start stays in IDLE and pulses cfg_err the next cycle.
  - start outside IDLE is ignored.
- Pixel acceptance: pix_ready = busy && (!win_valid || win_ready). pix_ready is 0 in IDLE.
- col counter:
  - Increments per accepted pixel.
  - At cfg_width-1 it wraps to 0 and the row counter increments.
  - The state toggles EVEN_ROW <-> ODD_ROW on each row wrap.
- EVEN_ROW: each accepted pixel is written to linebuf[col].
- ODD_ROW:
  - Even col: the pixel is stored in the hold register.
  - Odd col: win_data <= {pix, hold, linebuf[col], linebuf[col-1]} (lanes 3..0), and win_valid <= 1.
- Odd cfg_width: the last column of every row is accepted and discarded, so there are floor(width/2) windows per row pair.
- Odd cfg_height: the last row is accepted into the line buffer but produces no windows.
- Window count per frame: floor(W/2)*floor(H/2).
- End of frame:
  - After the last pixel (row H-1, col W-1) is accepted, frame_done pulses the next cycle, busy drops, and the state returns to IDLE.
  - A pending window stays valid until consumed.
- win_valid clears on win_valid && win_ready unless a new window is loaded in the same cycle, in which case it stays 1 with the new data.
- Data is unsigned pass-through; no arithmetic on pixel values.
- Reset values: pix_ready=0, win_valid=0, win_data=0, busy=0, frame_done=0, cfg_err=0, state IDLE, counters 0. Line buffer contents are don't-care.
- Reset mid-frame aborts the frame immediately. No frame_done is produced and any pending window is dropped.

## Timing
- Latency: the window appears (win_valid=1) on the clock edge following acceptance of its bottom-right pixel, i.e. 1 cycle.
- Full throughput with win_ready held high: 1 pixel/cycle, with no bubbles across row or frame boundaries within a frame.
- The output register holds win_data stable while win_valid && !win_ready. pix_ready is low during that stall, so no pixel is lost or overwritten.
- busy rises the cycle after an accepted start and falls in the same cycle frame_done pulses.
- A new start is accepted in the cycle frame_done is high (state is IDLE), even while a final window is still pending.

## Test plan
- 4x4 frame, pixels 0..15, win_ready=1 -> windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15} in lane order [0..3]. Each window appears 1 cycle after pixels 5/7/13/15; frame_done 1 cycle after pixel 15.
- Same frame with win_ready held 0 for 5 cycles after the first window -> win_data={0,1,4,5} stable, pix_ready=0 throughout the stall, no pixels dropped; remaining windows identical to the first scenario.
- 5x2 frame, pixels 0..9 -> exactly 2 windows: {0,1,5,6} and {2,3,7,8}. Pixels 4 and 9 are accepted and discarded; frame_done asserts.
- 4x3 frame, pixels 0..11 -> 2 windows: {0,1,4,5} and {2,3,6,7}. Row 2 (pixels 8..11) is accepted with no window; frame_done after pixel 11.
- start with cfg_width=1, then cfg_width=MAX_WIDTH+1, then cfg_height=1 -> cfg_err pulse each time, busy stays 0, pix_ready stays 0.
- rst_n asserted after 6 pixels of a 4x4 frame -> all outputs return to reset values asynchronously. A subsequent fresh 4x4 frame produces the windows of the first scenario.

Source files
------------

// File: rtl/pool_window_gen_if.sv
// Stream bundle for the 2x2 pooling window generator: pixel input stream
// and assembled-window output stream, each with a valid/ready handshake.
interface pool_window_gen_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]   pix_data;
    logic                    pix_valid;
    logic                    pix_ready;
    logic [4*DATA_WIDTH-1:0] win_data;
    logic                    win_valid;
    logic                    win_ready;

    // Producer of pixels / consumer of windows
    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready,
        input  win_data,
        input  win_valid,
        output win_ready
    );

    // The window generator itself
    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        output win_data,
        output win_valid,
        input  win_ready
    );
endinterface

// File: rtl/pool_window_gen.sv
// Turns a raster-order pixel stream into non-overlapping 2x2 pooling windows.
// Even rows are parked in a line buffer; odd rows complete the windows.
module pool_window_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WIDTH  = 64,
    parameter int CW         = $clog2(MAX_WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [CW-1:0]        cfg_width_i,
    input  logic [CW-1:0]        cfg_height_i,
    pool_window_gen_if.slave     stream,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 cfg_err_o
);
    // The line buffer stores horizontal pixel pairs, so one read returns
    // both top pixels of a window.
    localparam int PAIRS = (MAX_WIDTH + 1) / 2;
    localparam int AW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_ROW = 2'd1,
        ODD_ROW  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           width_q, width_d;
    logic [CW-1:0]           height_q, height_d;
    logic [CW-1:0]           col_q, col_d;
    logic [CW-1:0]           row_q, row_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic [4*DATA_WIDTH-1:0] win_data_q, win_data_d;
    logic                    win_valid_q, win_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    cfg_err_q, cfg_err_d;

    logic [2*DATA_WIDTH-1:0] linebuf [PAIRS];
    logic [2*DATA_WIDTH-1:0] rd_q;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [AW-1:0]           rd_addr;
    logic [2*DATA_WIDTH-1:0] wr_data;

    logic                    busy;
    logic                    pix_ready;
    logic                    accept;
    logic                    last_col;
    logic                    last_row;
    logic                    cfg_ok;
    logic [DATA_WIDTH-1:0]   lane [4];
    logic [4*DATA_WIDTH-1:0] win_lanes;

    assign busy      = (state_q != IDLE);
    assign pix_ready = busy && (!win_valid_q || stream.win_ready);
    assign accept    = stream.pix_valid && pix_ready;
    assign last_col  = (col_q == width_q - CW'(1));
    assign last_row  = (row_q == height_q - CW'(1));
    assign cfg_ok    = (cfg_width_i >= CW'(2)) && (cfg_width_i <= CW'(MAX_WIDTH))
                    && (cfg_height_i >= CW'(2));

    // Lane order: top-left, top-right, bottom-left, bottom-right
    assign lane[0] = rd_q[DATA_WIDTH-1:0];
    assign lane[1] = rd_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign lane[2] = hold_q;
    assign lane[3] = stream.pix_data;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign win_lanes[gi*DATA_WIDTH +: DATA_WIDTH] = lane[gi];
        end
    endgenerate

    // Reading at the next column's pair keeps rd_q aligned with col_q, so the
    // top pair is already registered when the odd-column pixel arrives.
    assign wr_addr = col_q[AW:1];
    assign rd_addr = col_d[AW:1];
    assign wr_data = {stream.pix_data, hold_q};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            linebuf[wr_addr] <= wr_data;
        end
        rd_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : linebuf[rd_addr];
    end

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        win_data_d   = win_data_q;
        win_valid_d  = win_valid_q && !stream.win_ready;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        wr_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        width_d  = cfg_width_i;
                        height_d = cfg_height_i;
                        col_d    = '0;
                        row_d    = '0;
                        state_d  = EVEN_ROW;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            EVEN_ROW, ODD_ROW: begin
                if (accept) begin
                    // A trailing even column of an odd-width row lands in
                    // hold_q and is simply never used.
                    if (!col_q[0]) begin
                        hold_d = stream.pix_data;
                    end else if (state_q == EVEN_ROW) begin
                        wr_en = 1'b1;
                    end else begin
                        win_data_d  = win_lanes;
                        win_valid_d = 1'b1;
                    end

                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + CW'(1);
                        if (last_row) begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            win_data_q   <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            win_data_q   <= win_data_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign stream.pix_ready = pix_ready;
    assign stream.win_data  = win_data_q;
    assign stream.win_valid = win_valid_q;
    assign busy_o           = busy;
    assign frame_done_o     = frame_done_q;
    assign cfg_err_o        = cfg_err_q;
endmodule

// File: tb/tb_pool_window_gen.sv
// Directed bench for pool_window_gen: full-rate frames, output stall,
// odd width/height, rejected configurations and mid-frame reset.
module tb_pool_window_gen;
    localparam int DW = 16;
    localparam int CW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [CW-1:0] cfg_width_i = '0;
    logic [CW-1:0] cfg_height_i = '0;
    logic          busy_o;
    logic          frame_done_o;
    logic          cfg_err_o;

    int errors = 0;
    int checks = 0;
    int nwin = 0;
    logic [63:0] win_q[$];

    // Hand-computed windows, lanes 3..0 = BR, BL, TR, TL
    logic [63:0] exp44 [4] = '{64'h0005_0004_0001_0000, 64'h0007_0006_0003_0002,
                               64'h000d_000c_0009_0008, 64'h000f_000e_000b_000a};
    logic [63:0] exp52 [2] = '{64'h0006_0005_0001_0000, 64'h0008_0007_0003_0002};

    pool_window_gen_if #(.DATA_WIDTH(DW)) ifc ();

    pool_window_gen #(.DATA_WIDTH(DW), .MAX_WIDTH(64), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .cfg_width_i  (cfg_width_i),
        .cfg_height_i (cfg_height_i),
        .stream       (ifc.slave),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .cfg_err_o    (cfg_err_o)
    );

    always #5 clk = ~clk;

    // Handshake is stable from the falling edge to the next rising edge.
    always @(negedge clk) begin
        if (ifc.win_valid && ifc.win_ready) begin
            win_q.push_back(ifc.win_data);
            $display("window %0d: %h", nwin, ifc.win_data);
            nwin++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h);
        cfg_width_i  = CW'(w);
        cfg_height_i = CW'(h);
        start_i      = 1'b1;
        cyc(1);
        start_i      = 1'b0;
    endtask

    // Offers one pixel and returns once it is accepted (bounded wait).
    task automatic send(input int v, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        ifc.pix_data  = v[DW-1:0];
        ifc.pix_valid = 1'b1;
        while (!ok && waits < 64) begin
            #1;
            if (ifc.pix_ready) ok = 1'b1;
            else waits++;
            cyc(1);
        end
        ifc.pix_valid = 1'b0;
        if (!ok) check("send timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int w;
        int idx;
        logic exp_v;
        ifc.pix_data  = '0;
        ifc.pix_valid = 1'b0;
        ifc.win_ready = 1'b1;

        // Reset state
        cyc(2);
        check("rst win_valid", 64'(ifc.win_valid), 64'd0);
        check("rst win_data", ifc.win_data, 64'd0);
        check("rst pix_ready", 64'(ifc.pix_ready), 64'd0);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst frame_done", 64'(frame_done_o), 64'd0);
        check("rst cfg_err", 64'(cfg_err_o), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        cyc(2);

        // 4x4 at full rate with per-pixel timing checks
        win_q.delete();
        do_start(4, 4);
        check("s1 busy", 64'(busy_o), 64'd1);
        check("s1 pix_ready", 64'(ifc.pix_ready), 64'd1);
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            send(i, w);
            check("s1 waits", 64'(w), 64'd0);
            exp_v = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            check("s1 win_valid", 64'(ifc.win_valid), 64'(exp_v));
            if (exp_v) begin
                check("s1 win_data", ifc.win_data, exp44[idx]);
                idx++;
            end
            check("s1 frame_done", 64'(frame_done_o), 64'(i == 15));
        end
        check("s1 busy end", 64'(busy_o), 64'd0);
        cyc(1);
        check("s1 frame_done pulse", 64'(frame_done_o), 64'd0);
        cyc(1);
        check("s1 nwin", 64'(win_q.size()), 64'd4);

        // 4x4 with a 5-cycle output stall after the first window
        win_q.delete();
        do_start(4, 4);
        for (int i = 0; i < 6; i++) send(i, w);
        ifc.win_ready = 1'b0;
        check("s2 win_valid", 64'(ifc.win_valid), 64'd1);
        ifc.pix_data  = 16'd6;
        ifc.pix_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("s2 stall pix_ready", 64'(ifc.pix_ready), 64'd0);
            check("s2 stall win_valid", 64'(ifc.win_valid), 64'd1);
            check("s2 stall win_data", ifc.win_data, exp44[0]);
            cyc(1);
        end
        ifc.win_ready = 1'b1;
        for (int i = 6; i < 16; i++) send(i, w);
        check("s2 frame_done", 64'(frame_done_o), 64'd1);
        cyc(2);
        check("s2 nwin", 64'(win_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < win_q.size(); i++) check("s2 window", win_q[i], exp44[i]);

        // 5x2: odd width, last column of each row discarded
        win_q.delete();
        do_start(5, 2);
        for (int i = 0; i < 10; i++) send(i, w);
        check("s3 frame_done", 64'(frame_done_o), 64'd1);
        check("s3 busy", 64'(busy_o), 64'd0);
        cyc(2);
        check("s3 nwin", 64'(win_q.size()), 64'd2);
        for (int i = 0; i < 2 && i < win_q.size(); i++) check("s3 window", win_q[i], exp52[i]);

        // 4x3: odd height, last row yields nothing
        win_q.delete();
        do_start(4, 3);
        for (int i = 0; i < 12; i++) begin
            send(i, w);
            check("s4 frame_done", 64'(frame_done_o), 64'(i == 11));
        end
        cyc(2);
        check("s4 nwin", 64'(win_q.size()), 64'd2);
        for (int i = 0; i < 2 && i < win_q.size(); i++) check("s4 window", win_q[i], exp44[i]);

        // Rejected configurations
        do_start(1, 4);
        check("s5 w1 cfg_err", 64'(cfg_err_o), 64'd1);
        check("s5 w1 busy", 64'(busy_o), 64'd0);
        check("s5 w1 pix_ready", 64'(ifc.pix_ready), 64'd0);
        cyc(1);
        check("s5 cfg_err pulse", 64'(cfg_err_o), 64'd0);
        do_start(65, 4);
        check("s5 w65 cfg_err", 64'(cfg_err_o), 64'd1);
        check("s5 w65 busy", 64'(busy_o), 64'd0);
        do_start(4, 1);
        check("s5 h1 cfg_err", 64'(cfg_err_o), 64'd1);
        check("s5 h1 pix_ready", 64'(ifc.pix_ready), 64'd0);
        cyc(1);

        // Reset after 6 pixels, then a clean 4x4 frame
        win_q.delete();
        do_start(4, 4);
        for (int i = 0; i < 6; i++) send(i, w);
        check("s6 pre-reset win_valid", 64'(ifc.win_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("s6 rst win_valid", 64'(ifc.win_valid), 64'd0);
        check("s6 rst win_data", ifc.win_data, 64'd0);
        check("s6 rst busy", 64'(busy_o), 64'd0);
        check("s6 rst pix_ready", 64'(ifc.pix_ready), 64'd0);
        cyc(2);
        check("s6 no frame_done", 64'(frame_done_o), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        cyc(1);
        check("s6 nwin after rst", 64'(win_q.size()), 64'd0);
        do_start(4, 4);
        for (int i = 0; i < 16; i++) send(i, w);
        check("s6 frame_done", 64'(frame_done_o), 64'd1);
        cyc(2);
        check("s6 nwin", 64'(win_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < win_q.size(); i++) check("s6 window", win_q[i], exp44[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
